// File: rtl/exec_seq_pkg.sv
// Shared definitions for the exec_sequencer control unit: opcodes, execute
// function selects, FSM states and instruction field positions.
package exec_seq_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MOV  = 4'h3;
    localparam logic [3:0] OP_INC  = 4'h4;
    localparam logic [3:0] OP_CLR  = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_BEQZ = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] FS_ZERO  = 3'd0;
    localparam logic [2:0] FS_ADD   = 3'd1;
    localparam logic [2:0] FS_SUB   = 3'd2;
    localparam logic [2:0] FS_PASSB = 3'd3;
    localparam logic [2:0] FS_INCB  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_t;

    // Low bit of each instruction field; register fields are 4 bits, imm/target 8.
    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 8;
    localparam int RA_LSB  = 4;
    localparam int RB_LSB  = 0;
    localparam int IMM_LSB = 0;
    localparam int TGT_LSB = 4;

endpackage

// File: rtl/exec_seq_decode.sv
// Combinational instruction decoder: IR -> execute controls and flow flags.
// Branch opcodes decode only when EXEC_SEQ_BRANCH_EN is defined.
module exec_seq_decode
    import exec_seq_pkg::*;
(
    input  logic [15:0] i_ir,
    output logic [2:0]  o_fs,
    output logic        o_b_sel,
    output logic        o_writes_rd,
    output logic        o_is_jmp,
    output logic        o_is_beqz,
    output logic        o_is_halt,
    output logic [15:0] o_imm
);
    logic [3:0] w_op;
    logic       w_unused_rd;

    assign w_op        = i_ir[OP_LSB +: 4];
    assign w_unused_rd = ^i_ir[RD_LSB +: 4];
    assign o_imm       = {8'h00, i_ir[IMM_LSB +: 8]};

    always_comb begin
        o_fs        = FS_ZERO;
        o_b_sel     = 1'b0;
        o_writes_rd = 1'b0;
        o_is_jmp    = 1'b0;
        o_is_beqz   = 1'b0;
        o_is_halt   = 1'b0;
        case (w_op)
            OP_ADD: begin o_fs = FS_ADD;   o_writes_rd = 1'b1; end
            OP_SUB: begin o_fs = FS_SUB;   o_writes_rd = 1'b1; end
            OP_MOV: begin o_fs = FS_PASSB; o_writes_rd = 1'b1; end
            OP_INC: begin o_fs = FS_INCB;  o_writes_rd = 1'b1; end
            OP_CLR: begin o_fs = FS_ZERO;  o_writes_rd = 1'b1; end
            OP_LDI: begin
                o_fs        = FS_PASSB;
                o_b_sel     = 1'b1;
                o_writes_rd = 1'b1;
            end
`ifdef EXEC_SEQ_BRANCH_EN
            OP_JMP:  o_is_jmp = 1'b1;
            // Pass rb through the execute unit so alu_out reflects reg[rb].
            OP_BEQZ: begin o_fs = FS_PASSB; o_is_beqz = 1'b1; end
`endif
            OP_HALT: o_is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/decode/exec/writeback controller for the mini CPU.
// Define EXEC_SEQ_BRANCH_EN to implement JMP and BEQZ.
module exec_sequencer
    import exec_seq_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int RF_AW = 4
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_ready,
    input  logic [15:0]      imem_rdata,
    output logic [RF_AW-1:0] rf_ra_addr,
    output logic [RF_AW-1:0] rf_rb_addr,
    output logic [RF_AW-1:0] rf_wa,
    output logic             rf_we,
    output logic             b_sel,
    output logic [15:0]      imm_out,
    output logic [2:0]       execute_fs,
    input  logic [15:0]      alu_out,
    output logic             busy,
    output logic             halted
);
    state_t          r_state, w_state_next;
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_ir;
    logic [PC_W-1:0] w_pc_next;
    logic            w_in_exwb;
    logic [2:0]      w_fs;
    logic            w_b_sel, w_writes_rd, w_is_jmp, w_is_beqz, w_is_halt;

    exec_seq_decode u_decode (
        .i_ir        (r_ir),
        .o_fs        (w_fs),
        .o_b_sel     (w_b_sel),
        .o_writes_rd (w_writes_rd),
        .o_is_jmp    (w_is_jmp),
        .o_is_beqz   (w_is_beqz),
        .o_is_halt   (w_is_halt),
        .o_imm       (imm_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        imem_req     = 1'b0;
        busy         = 1'b0;
        halted       = 1'b0;
        w_in_exwb    = 1'b0;
        case (r_state)
            ST_IDLE:   if (start) w_state_next = ST_FETCH;
            ST_FETCH: begin
                busy     = 1'b1;
                imem_req = 1'b1;
                if (imem_ready) w_state_next = ST_DECODE;
            end
            ST_DECODE: begin
                busy         = 1'b1;
                w_state_next = ST_EXEC;
            end
            ST_EXEC: begin
                busy         = 1'b1;
                w_in_exwb    = 1'b1;
                w_state_next = ST_WB;
            end
            ST_WB: begin
                busy         = 1'b1;
                w_in_exwb    = 1'b1;
                w_state_next = w_is_halt ? ST_HALT : ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
                if (start) w_state_next = ST_FETCH;
            end
            default:   w_state_next = ST_IDLE;
        endcase
    end

`ifdef EXEC_SEQ_BRANCH_EN
    logic w_take_branch;
    // alu_out carries reg[rb] here because fs/rb_addr are still held in WB.
    assign w_take_branch = w_is_jmp | (w_is_beqz & (alu_out == 16'h0000));
    assign w_pc_next     = w_take_branch ? PC_W'(r_ir[TGT_LSB +: 8]) : r_pc + PC_W'(1);
`else
    logic w_unused_branch;
    assign w_unused_branch = ^{alu_out, w_is_jmp, w_is_beqz};
    assign w_pc_next       = r_pc + PC_W'(1);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= '0;
            r_ir <= '0;
        end else begin
            if ((r_state == ST_IDLE || r_state == ST_HALT) && start)
                r_pc <= '0;
            else if (r_state == ST_WB)
                r_pc <= w_pc_next;
            if (r_state == ST_FETCH && imem_ready)
                r_ir <= imem_rdata;
        end
    end

    assign imem_addr  = r_pc;
    assign rf_ra_addr = RF_AW'(r_ir[RA_LSB +: 4]);
    assign rf_rb_addr = RF_AW'(r_ir[RB_LSB +: 4]);
    assign rf_wa      = RF_AW'(r_ir[RD_LSB +: 4]);
    assign rf_we      = (r_state == ST_WB) & w_writes_rd;
    assign execute_fs = w_in_exwb ? w_fs : FS_ZERO;
    assign b_sel      = w_in_exwb & w_b_sel;

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Multi-cycle control unit for the mini CPU. It fetches 16-bit instructions over a ready-based memory handshake and decodes them. It then drives the 16-bit execute unit (function select, B-operand source), register-file read/write addresses and the program counter. It is the only master of the execute unit's function-select input.

## Interface
- PC_W, 8, program-counter / instruction-address width
- RF_AW, 4, register-file address width (16 registers)
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- start  in  1  one-cycle pulse; begins execution at PC 0 from IDLE or HALT
- imem_req  out  1  fetch request, held until imem_ready
- imem_addr  out  PC_W  fetch address (= PC)
- imem_ready  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  16  instruction word
- rf_ra_addr  out  RF_AW  read port A address (execute in_A)
- rf_rb_addr  out  RF_AW  read port B address (execute in_B when b_sel=0)
- rf_wa  out  RF_AW  write address
- rf_we  out  1  register write strobe; write data = execute output
- b_sel  out  1  execute in_B source: 0 = rf port B, 1 = imm_out
- imm_out  out  16  zero-extended 8-bit immediate
- execute_fs  out  3  execute function select: 0 zero, 1 A+B, 2 A−B, 3 pass B, 4 B+1
- alu_out  in  16  execute result (used for branch-zero test)
- busy  out  1  high in FETCH/DECODE/EXEC/WB
- halted  out  1  high in HALT

## Operation
- Instruction formats: register op = op[15:12] rd[11:8] ra[7:4] rb[3:0]; LDI = op rd imm8[7:0]; branch = op target[11:4] rb[3:0].
- Opcodes: 0 NOP; 1 ADD rd=ra+rb (fs 1); 2 SUB rd=ra−rb (fs 2); 3 MOV rd=rb (fs 3); 4 INC rd=rb+1 (fs 4); 5 CLR rd=0 (fs 0); 6 LDI rd=imm8 (fs 3, b_sel 1); 7 JMP pc=target; 8 BEQZ pc=target if reg[rb]==0 (fs 3); F HALT; 9–E illegal → NOP.
- FSM states: IDLE, FETCH, DECODE, EXEC, WB, HALT.
  - IDLE/HALT --start--> FETCH, with PC cleared to 0.
  - FETCH --imem_ready--> DECODE; IR captured.
  - DECODE → EXEC → WB, one cycle each.
  - WB → FETCH, or HALT if the opcode was F.
- The DECODE state drives rf_ra_addr/rf_rb_addr from IR. The addresses, execute_fs, b_sel and imm_out are held through EXEC and WB.
- WB: rf_we=1 for one cycle only for opcodes 1–6; rf_wa=rd. Branch PC is loaded in WB; otherwise PC = PC+1.
- Outside EXEC/WB: execute_fs=0, b_sel=0, rf_we=0.
- Arithmetic wrap is the execute unit's concern; the controller never inspects overflow.

## Timing
- Reset values: state IDLE, PC 0, IR 0, imem_req 0, imem_addr 0, all rf addresses 0, rf_we 0, b_sel 0, imm_out 0, execute_fs 0, busy 0, halted 0.
- Latency: 4 cycles per instruction when imem_ready is high in the first FETCH cycle; each stall cycle adds one.
- imem_req rises on entry to FETCH and is held with a stable imem_addr until imem_ready. It drops the cycle after imem_ready.
- imem_ready while imem_req=0 is ignored. start while busy is ignored.
- PC wraps from 2^PC_W−1 to 0 with no error.
- rst asserted mid-instruction clears state immediately; no partial rf_we pulse survives.
- BEQZ evaluates alu_out==0 in WB, while fs 3 and rf_rb_addr=rb are still held.

## Configuration
- EXEC_SEQ_BRANCH_EN defined: JMP and BEQZ are implemented as above.
- EXEC_SEQ_BRANCH_EN undefined: opcodes 7 and 8 decode as illegal (NOP, PC+1), and no branch-target mux is built.

## Structure
- Shared package exec_seq_pkg holds:
  - opcode constants
  - execute function-select constants (FS_ZERO, FS_ADD, FS_SUB, FS_PASSB, FS_INCB)
  - state enum
  - instruction field position localparams
- Sub-module exec_seq_decode: combinational IR → {fs, b_sel, writes_rd, is_jmp, is_beqz, is_halt, imm}. The FSM and PC stay in the top level.

## Test plan
- Reset while imem_req=1 → imem_req 0, busy 0, execute_fs 0 in the same cycle, without waiting for a clock edge.
- start; program [LDI r1,5; LDI r2,3; SUB r3,r1,r2; HALT] → rf_we pulses with rf_wa 1,2,3 and fs 3,3,2; halted=1 after 16 cycles.
- imem_ready withheld 3 cycles on the first fetch → imem_req and imem_addr 0 stable; DECODE entered the cycle after ready; instruction takes 7 cycles.
- BEQZ target 0x20, rb holding 0 (alu_out 0) → next imem_addr 0x20; alu_out 0x0001 → next imem_addr PC+1. Without EXEC_SEQ_BRANCH_EN → always PC+1.
- Opcode 0xA, then CLR r4 → no write for 0xA; CLR gives rf_we with fs 0 and rf_wa 4.
- PC at 0xFF executing NOP → next imem_addr 0x00; start pulses during busy have no effect.
